// File: rtl/ika9958_vram_pkg.sv
// Shared types for the IKA9958 VRAM slot scheduler: slot kinds, scheduler
// states, requester identities and the saturating starvation increment.
package ika9958_vram_pkg;

  typedef enum logic [1:0] {
    DISP = 2'b00,
    RFSH = 2'b01,
    FREE = 2'b10,
    RSVD = 2'b11
  } slot_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } sched_state_t;

  typedef enum logic {
    CPU = 1'b0,
    CMD = 1'b1
  } req_id_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/ika9958_vram_rdport.sv
// Per-requester read return: latches VRAM data on the capture cycle and
// pulses valid on the following cycle; data holds until the next capture.
module ika9958_vram_rdport #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cap,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_valid
);

  logic [DW-1:0] data_q;
  logic          valid_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= i_cap;
      if (i_cap) data_q <= i_data;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;

endmodule

// File: rtl/ika9958_vram_sched.sv
// VRAM slot scheduler: grants free slots to CPU or command engine (with
// starvation override), issues refresh cycles, and returns read data.
module ika9958_vram_sched
  import ika9958_vram_pkg::*;
#(
  parameter int AW     = 17,
  parameter int DW     = 8,
  parameter int STARVE = 4,
  parameter int RDLAT  = 2
) (
  input  logic          i_EMUCLK,
  input  logic          i_RST,
  input  logic          i_slot_stb,
  input  logic [1:0]    i_slot_type,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  input  logic          i_cmd_req,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [DW-1:0] i_cmd_wdata,
  output logic          o_cpu_ack,
  output logic          o_cmd_ack,
  output logic [DW-1:0] o_cpu_rdata,
  output logic [DW-1:0] o_cmd_rdata,
  output logic          o_cpu_rvalid,
  output logic          o_cmd_rvalid,
  output logic          o_mem_stb,
  output logic          o_mem_rfsh,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy,
  output logic          o_ovr,
  output logic [1:0]    o_dbg_state
);

  // Requesters hold req/we/addr/wdata stable from request until the cycle
  // after their one-cycle ack; requests are only looked at on a slot strobe.

  sched_state_t  state_q;
  req_id_t       owner_q;
  logic [3:0]    starve_q;
  logic [2:0]    rd_cnt_q;
  logic          is_read_q;
  logic          mem_stb_q, mem_rfsh_q, mem_we_q;
  logic          cpu_ack_q, cmd_ack_q, ovr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  slot_type_t slot_type;
  logic       any_req, cmd_wins, last_wait, cap_cpu, cap_cmd;

  assign slot_type = slot_type_t'(i_slot_type);
  assign any_req   = i_cpu_req | i_cmd_req;
  // CPU has priority unless the command engine has been starved long enough.
  assign cmd_wins  = i_cmd_req & (~i_cpu_req | (starve_q == 4'(STARVE)));
  assign last_wait = (state_q == WAIT) && (rd_cnt_q == 3'd1);
  assign cap_cpu   = last_wait && is_read_q && (owner_q == CPU);
  assign cap_cmd   = last_wait && is_read_q && (owner_q == CMD);

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      state_q    <= IDLE;
      owner_q    <= CPU;
      starve_q   <= 4'd0;
      rd_cnt_q   <= 3'd0;
      is_read_q  <= 1'b0;
      mem_stb_q  <= 1'b0;
      mem_rfsh_q <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      cmd_ack_q  <= 1'b0;
      ovr_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      mem_stb_q  <= 1'b0;
      mem_rfsh_q <= 1'b0;
      cpu_ack_q  <= 1'b0;
      cmd_ack_q  <= 1'b0;
      if (i_slot_stb && (state_q != IDLE)) ovr_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (i_slot_stb && (slot_type == RFSH)) begin
            state_q    <= ISSUE;
            mem_stb_q  <= 1'b1;
            mem_rfsh_q <= 1'b1;
            mem_we_q   <= 1'b0;
            is_read_q  <= 1'b0;
          end else if (i_slot_stb && (slot_type == FREE) && any_req) begin
            state_q   <= ISSUE;
            mem_stb_q <= 1'b1;
            if (cmd_wins) begin
              owner_q   <= CMD;
              cmd_ack_q <= 1'b1;
              mem_we_q  <= i_cmd_we;
              is_read_q <= ~i_cmd_we;
              addr_q    <= i_cmd_addr;
              wdata_q   <= i_cmd_wdata;
              starve_q  <= 4'd0;
            end else begin
              owner_q   <= CPU;
              cpu_ack_q <= 1'b1;
              mem_we_q  <= i_cpu_we;
              is_read_q <= ~i_cpu_we;
              addr_q    <= i_cpu_addr;
              wdata_q   <= i_cpu_wdata;
              if (i_cmd_req) starve_q <= sat_inc4(starve_q, 4'(STARVE));
            end
          end
        end
        ISSUE: begin
          state_q  <= WAIT;
          rd_cnt_q <= 3'(RDLAT);
        end
        WAIT: begin
          rd_cnt_q <= rd_cnt_q - 3'd1;
          if (rd_cnt_q == 3'd1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ika9958_vram_rdport #(.DW(DW)) u_cpu_rd (
    .i_clk   (i_EMUCLK),
    .i_rst   (i_RST),
    .i_cap   (cap_cpu),
    .i_data  (i_mem_rdata),
    .o_data  (o_cpu_rdata),
    .o_valid (o_cpu_rvalid)
  );

  ika9958_vram_rdport #(.DW(DW)) u_cmd_rd (
    .i_clk   (i_EMUCLK),
    .i_rst   (i_RST),
    .i_cap   (cap_cmd),
    .i_data  (i_mem_rdata),
    .o_data  (o_cmd_rdata),
    .o_valid (o_cmd_rvalid)
  );

  assign o_cpu_ack   = cpu_ack_q;
  assign o_cmd_ack   = cmd_ack_q;
  assign o_mem_stb   = mem_stb_q;
  assign o_mem_rfsh  = mem_rfsh_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_busy      = (state_q != IDLE);
  assign o_ovr       = ovr_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_ika9958_vram_sched.sv
// Directed bench for ika9958_vram_sched: expected issues and read returns are
// queued by the driver and matched (including cycle of arrival) by a monitor.
module tb_ika9958_vram_sched;

  localparam int AW = 17;
  localparam int DW = 8;
  localparam int STARVE = 4;
  localparam int RDLAT = 2;
  localparam int IW = 16 + 4 + AW + DW;
  localparam int RW = 16 + 1 + DW;

  localparam logic [1:0] ST_DISP = 2'b00;
  localparam logic [1:0] ST_RFSH = 2'b01;
  localparam logic [1:0] ST_FREE = 2'b10;
  localparam logic [1:0] ST_RSVD = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          i_slot_stb, i_cpu_req, i_cpu_we, i_cmd_req, i_cmd_we;
  logic [1:0]    i_slot_type;
  logic [AW-1:0] i_cpu_addr, i_cmd_addr;
  logic [DW-1:0] i_cpu_wdata, i_cmd_wdata, i_mem_rdata;
  logic          o_cpu_ack, o_cmd_ack, o_cpu_rvalid, o_cmd_rvalid;
  logic          o_mem_stb, o_mem_rfsh, o_mem_we, o_busy, o_ovr;
  logic [DW-1:0] o_cpu_rdata, o_cmd_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;
  logic [1:0]    o_dbg_state;

  ika9958_vram_sched #(.AW(AW), .DW(DW), .STARVE(STARVE), .RDLAT(RDLAT)) dut (
    .i_EMUCLK     (clk),
    .i_RST        (rst),
    .i_slot_stb   (i_slot_stb),
    .i_slot_type  (i_slot_type),
    .i_cpu_req    (i_cpu_req),
    .i_cpu_we     (i_cpu_we),
    .i_cpu_addr   (i_cpu_addr),
    .i_cpu_wdata  (i_cpu_wdata),
    .i_cmd_req    (i_cmd_req),
    .i_cmd_we     (i_cmd_we),
    .i_cmd_addr   (i_cmd_addr),
    .i_cmd_wdata  (i_cmd_wdata),
    .o_cpu_ack    (o_cpu_ack),
    .o_cmd_ack    (o_cmd_ack),
    .o_cpu_rdata  (o_cpu_rdata),
    .o_cmd_rdata  (o_cmd_rdata),
    .o_cpu_rvalid (o_cpu_rvalid),
    .o_cmd_rvalid (o_cmd_rvalid),
    .o_mem_stb    (o_mem_stb),
    .o_mem_rfsh   (o_mem_rfsh),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata),
    .o_busy       (o_busy),
    .o_ovr        (o_ovr),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [IW-1:0] exp_iss_q[$];
  logic [RW-1:0] exp_rd_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_iss(input logic rf, input logic we, input logic ca, input logic ma,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input int at);
    exp_iss_q.push_back({16'(at), rf, we, ca, ma, a, d});
  endtask

  task automatic push_rd(input logic who, input logic [DW-1:0] d, input int at);
    exp_rd_q.push_back({16'(at), who, d});
  endtask

  task automatic match_rd(input logic who);
    logic [RW-1:0] got_r, exp_r;
    got_r = {16'(cyc), who, who ? o_cmd_rdata : o_cpu_rdata};
    n_vec++;
    if (exp_rd_q.size() == 0) begin
      n_err++;
      $display("FAIL rvalid_unexpected got=%h exp=none", got_r);
    end else begin
      exp_r = exp_rd_q.pop_front();
      if (got_r !== exp_r) begin
        n_err++;
        $display("FAIL rvalid got=%h exp=%h", got_r, exp_r);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [IW-1:0] got_i, exp_i;
    if (o_mem_stb) begin
      got_i = {16'(cyc), o_mem_rfsh, o_mem_we, o_cpu_ack, o_cmd_ack, o_mem_addr, o_mem_wdata};
      n_vec++;
      if (exp_iss_q.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected got=%h exp=none", got_i);
      end else begin
        exp_i = exp_iss_q.pop_front();
        if (got_i !== exp_i) begin
          n_err++;
          $display("FAIL issue got=%h exp=%h", got_i, exp_i);
        end
      end
    end
    if ((o_cpu_ack | o_cmd_ack) && !o_mem_stb) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_without_stb got=%b%b exp=00", o_cpu_ack, o_cmd_ack);
    end
    if (o_cpu_rvalid) match_rd(1'b0);
    if (o_cmd_rvalid) match_rd(1'b1);
  end

  // ---------------- driver tasks ----------------
  // Entered and left at a falling edge; the strobe cycle is the current cyc.
  task automatic slot(input logic [1:0] t, input int gap);
    i_slot_stb  = 1'b1;
    i_slot_type = t;
    @(negedge clk);
    i_slot_stb  = 1'b0;
    i_slot_type = ST_DISP;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic free_both(input logic cmd_win);
    if (cmd_win) push_iss(1'b0, i_cmd_we, 1'b0, 1'b1, i_cmd_addr, i_cmd_wdata, cyc + 1);
    else         push_iss(1'b0, i_cpu_we, 1'b1, 1'b0, i_cpu_addr, i_cpu_wdata, cyc + 1);
    slot(ST_FREE, 6);
  endtask

  logic exp_cmd[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({o_mem_stb, o_mem_rfsh, o_mem_we, o_cpu_ack, o_cmd_ack,
                               o_cpu_rvalid, o_cmd_rvalid, o_busy, o_ovr, o_dbg_state}), 32'd0);
    check({tag, "_addr"}, 32'(o_mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(o_mem_wdata), 32'd0);
    check({tag, "_cpu_rdata"}, 32'(o_cpu_rdata), 32'd0);
    check({tag, "_cmd_rdata"}, 32'(o_cmd_rdata), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_slot_stb = 1'b0; i_slot_type = ST_DISP;
    i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = '0; i_cpu_wdata = '0;
    i_cmd_req = 1'b0; i_cmd_we = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0;
    i_mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // slots that must not start an access
    i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 17'h00555; i_cpu_wdata = 8'h99;
    slot(ST_DISP, 1);
    check("disp_noop", 32'(o_dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    slot(ST_RSVD, 1);
    check("rsvd_noop", 32'(o_dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    i_cpu_req = 1'b0;
    slot(ST_FREE, 1);
    check("free_noreq_noop", 32'(o_busy), 32'd0);
    repeat (2) @(negedge clk);

    // CPU read: ack at T+1, rvalid with 0x5A at T+4
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 17'h1ABCD; i_cpu_wdata = 8'h00;
    i_mem_rdata = 8'h5A;
    push_iss(1'b0, 1'b0, 1'b1, 1'b0, 17'h1ABCD, 8'h00, cyc + 1);
    push_rd(1'b0, 8'h5A, cyc + 4);
    slot(ST_FREE, 1);
    check("cpu_rd_busy_issue", 32'({o_busy, o_dbg_state}), 32'b101);
    @(negedge clk);
    i_cpu_req = 1'b0; i_cpu_addr = '0;
    check("cpu_rd_wait", 32'(o_dbg_state), 32'd2);
    repeat (2) @(negedge clk);
    check("cpu_rd_idle_again", 32'(o_busy), 32'd0);
    i_mem_rdata = 8'hEE;
    repeat (3) @(negedge clk);
    check("cpu_rdata_hold", 32'(o_cpu_rdata), 32'h5A);

    // both requesting writes: CPU x4, CMD, CPU x4, CMD
    i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 17'h00100; i_cpu_wdata = 8'h11;
    i_cmd_req = 1'b1; i_cmd_we = 1'b1; i_cmd_addr = 17'h00200; i_cmd_wdata = 8'h22;
    for (int i = 0; i < 10; i++) free_both(exp_cmd[i]);

    // refresh and display slots leave starvation count alone
    free_both(1'b0);
    free_both(1'b0);
    push_iss(1'b1, 1'b0, 1'b0, 1'b0, 17'h00100, 8'h11, cyc + 1);
    slot(ST_RFSH, 6);
    slot(ST_DISP, 6);
    free_both(1'b0);
    free_both(1'b0);
    free_both(1'b1);

    // overrun: second strobe two cycles later is dropped, count unchanged
    check("ovr_before", 32'(o_ovr), 32'd0);
    push_iss(1'b0, 1'b1, 1'b1, 1'b0, 17'h00100, 8'h11, cyc + 1);
    i_slot_stb = 1'b1; i_slot_type = ST_FREE;
    @(negedge clk);
    i_slot_stb = 1'b0;
    @(negedge clk);
    i_slot_stb = 1'b1;
    @(negedge clk);
    i_slot_stb = 1'b0;
    check("ovr_set", 32'(o_ovr), 32'd1);
    repeat (3) @(negedge clk);
    free_both(1'b0);
    free_both(1'b0);
    free_both(1'b0);
    free_both(1'b1);
    check("ovr_sticky", 32'(o_ovr), 32'd1);

    // CMD write, req dropped after ack: single issue, no read return
    i_cpu_req = 1'b0;
    i_cmd_req = 1'b1; i_cmd_we = 1'b1; i_cmd_addr = 17'h00010; i_cmd_wdata = 8'hC3;
    push_iss(1'b0, 1'b1, 1'b0, 1'b1, 17'h00010, 8'hC3, cyc + 1);
    slot(ST_FREE, 1);
    @(negedge clk);
    i_cmd_req = 1'b0;
    repeat (4) @(negedge clk);
    slot(ST_FREE, 6);
    check("cmd_wr_no_repeat", 32'(o_dbg_state), 32'd0);

    // CMD read returns on the command port only
    i_cmd_req = 1'b1; i_cmd_we = 1'b0; i_cmd_addr = 17'h0ABCD;
    i_mem_rdata = 8'h3C;
    push_iss(1'b0, 1'b0, 1'b0, 1'b1, 17'h0ABCD, 8'hC3, cyc + 1);
    push_rd(1'b1, 8'h3C, cyc + 4);
    slot(ST_FREE, 2);
    i_cmd_req = 1'b0;
    repeat (5) @(negedge clk);
    check("cmd_rdata", 32'(o_cmd_rdata), 32'h3C);
    check("cpu_rdata_untouched", 32'(o_cpu_rdata), 32'h5A);

    // reset in the middle of a read: immediate clear, no late rvalid
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 17'h12345; i_cpu_wdata = 8'h00;
    i_mem_rdata = 8'h77;
    push_iss(1'b0, 1'b0, 1'b1, 1'b0, 17'h12345, 8'h00, cyc + 1);
    slot(ST_FREE, 2);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    i_cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("post_reset_rdata", 32'(o_cpu_rdata), 32'd0);
    check("post_reset_ovr", 32'(o_ovr), 32'd0);

    check("issue_queue_drained", 32'(exp_iss_q.size()), 32'd0);
    check("rvalid_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
